// File: rtl/eth_fcs_check.sv
// Receive-side FCS checker for the 64-bit XGMII RX path: tracks /S/../T/ frame
// boundaries, runs CRC-32 over all post-SFD bytes, reports per-frame status and counts.
module eth_fcs_check #(
    parameter int unsigned MIN_LEN   = 64,
    parameter int unsigned MAX_LEN   = 1518,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           xgmii_ctrl,
    input  logic [63:0]          xgmii_data,
    output logic                 frame_done,
    output logic                 fcs_ok,
    output logic                 len_err,
    output logic                 ctrl_err,
    output logic                 frame_good,
    output logic [15:0]          frame_len,
    output logic [CNT_WIDTH-1:0] good_cnt,
    output logic [CNT_WIDTH-1:0] bad_cnt
);

    // LSB-first (reflected) register: same arithmetic as the bit-reversed forward
    // blocks, so the good-frame residue appears here as 0xDEBB20E3.
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    typedef enum logic {IDLE, DATA} state_t;

    state_t      state;
    logic [31:0] crc;
    logic [31:0] crc_upd;
    logic [15:0] count;
    logic [15:0] count_upd;
    logic [16:0] count_sum;
    logic [3:0]  k;
    logic [7:0]  lane_k;
    logic        sfd;
    logic        is_term;
    logic        done_now;
    logic        done_crc_ok;
    logic        done_cerr;
    logic        done_lerr;
    logic        done_good;
    logic [15:0] done_len;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int unsigned i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    always_comb begin
        // k = lowest lane carrying a control character, 8 when the word is all data
        k      = 4'd8;
        lane_k = '0;
        for (int unsigned i = 8; i > 0; i--) begin
            if (xgmii_ctrl[i-1]) begin
                k      = 4'(i - 1);
                lane_k = xgmii_data[8*(i-1) +: 8];
            end
        end

        sfd     = (xgmii_ctrl == 8'h01) && (xgmii_data[7:0] == 8'hFB) && (xgmii_data[63:56] == 8'hD5);
        is_term = (k != 4'd8) && (lane_k == 8'hFD) && (xgmii_ctrl == (8'hFF << k));

        crc_upd = crc;
        for (int unsigned j = 0; j < 8; j++) begin
            if (4'(j) < k)
                crc_upd = crc_byte(crc_upd, xgmii_data[8*j +: 8]);
        end

        count_sum = {1'b0, count} + {13'h0, k};
        count_upd = count_sum[16] ? '1 : count_sum[15:0];

        done_now    = 1'b0;
        done_crc_ok = 1'b0;
        done_cerr   = 1'b0;
        done_len    = count;
        if (state == DATA && xgmii_ctrl != '0) begin
            done_now = 1'b1;
            if (is_term) begin
                done_len    = count_upd;
                done_crc_ok = (crc_upd == RESIDUE);
            end else begin
                done_cerr = 1'b1;
            end
        end
        done_lerr = (32'(done_len) < MIN_LEN) || (32'(done_len) > MAX_LEN);
        done_good = done_crc_ok && !done_lerr && !done_cerr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            crc        <= '1;
            count      <= '0;
            frame_done <= 1'b0;
            fcs_ok     <= 1'b0;
            len_err    <= 1'b0;
            ctrl_err   <= 1'b0;
            frame_good <= 1'b0;
            frame_len  <= '0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (sfd) begin
                        state <= DATA;
                        crc   <= '1;
                        count <= '0;
                    end
                end
                DATA: begin
                    if (xgmii_ctrl == '0) begin
                        crc   <= crc_upd;
                        count <= count_upd;
                    end else if (is_term || !sfd) begin
                        state <= IDLE;
                    end else begin
                        // /S/ inside a frame: old frame is reported, new one starts now
                        crc   <= '1;
                        count <= '0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (done_now) begin
                frame_done <= 1'b1;
                fcs_ok     <= done_crc_ok;
                len_err    <= done_lerr;
                ctrl_err   <= done_cerr;
                frame_good <= done_good;
                frame_len  <= done_len;
                if (done_good)
                    good_cnt <= good_cnt + CNT_WIDTH'(1);
                else
                    bad_cnt  <= bad_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_eth_fcs_check.sv
// Directed bench for eth_fcs_check: frames are built as byte lists with a
// standard CRC-32 FCS; expected completions are queued and checked each cycle.
module tb_eth_fcs_check;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  xgmii_ctrl;
    logic [63:0] xgmii_data;
    logic        frame_done, fcs_ok, len_err, ctrl_err, frame_good;
    logic [15:0] frame_len;
    logic [31:0] good_cnt, bad_cnt;

    eth_fcs_check #(.MIN_LEN(64), .MAX_LEN(1518), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .xgmii_ctrl(xgmii_ctrl), .xgmii_data(xgmii_data),
        .frame_done(frame_done), .fcs_ok(fcs_ok), .len_err(len_err), .ctrl_err(ctrl_err),
        .frame_good(frame_good), .frame_len(frame_len), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        bit ok;
        bit lerr;
        bit cerr;
        int len;
    } exp_t;

    localparam logic [63:0] IDLE_WORD = {8{8'h07}};
    localparam logic [63:0] SFD_WORD  = {8'hD5, {6{8'h55}}, 8'hFB};

    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          mgood = 0;
    int          mbad = 0;
    exp_t        expq[$];
    logic [7:0]  fb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] crc_bytes(input logic [7:0] q[$], input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, q[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic drive(input logic [7:0] c, input logic [63:0] d, output int due);
        @(posedge clk);
        #1;
        xgmii_ctrl = c;
        xgmii_data = d;
        due = cyc + 1;
    endtask

    task automatic idle(input int n);
        int due;
        for (int i = 0; i < n; i++) drive(8'hFF, IDLE_WORD, due);
    endtask

    // Frame of n bytes DA..FCS with random payload; flip corrupts one FCS bit.
    task automatic make_frame(input int n, input bit flip);
        logic [31:0] f;
        fb.delete();
        for (int i = 0; i < n - 4; i++) fb.push_back(8'($urandom));
        f = crc_bytes(fb, n - 4);
        for (int i = 0; i < 4; i++) fb.push_back(f[8*i +: 8]);
        if (flip) fb[n-1] = fb[n-1] ^ 8'h10;
    endtask

    task automatic send_frame(input bit restart);
        int          due, n, i, k;
        logic [63:0] d;
        logic [31:0] f;
        exp_t        e;
        drive(8'h01, SFD_WORD, due);
        if (restart) begin
            e = '{due: due, ok: 1'b0, lerr: 1'b0, cerr: 1'b1, len: -1};
            expq.push_back(e);
        end
        n = fb.size();
        i = 0;
        while (n - i >= 8) begin
            for (int j = 0; j < 8; j++) d[8*j +: 8] = fb[i+j];
            drive(8'h00, d, due);
            i += 8;
        end
        k = n - i;
        d = IDLE_WORD;
        for (int j = 0; j < k; j++) d[8*j +: 8] = fb[i+j];
        d[8*k +: 8] = 8'hFD;
        drive(8'hFF << k, d, due);
        f = crc_bytes(fb, n - 4);
        e.due  = due;
        e.ok   = ({fb[n-1], fb[n-2], fb[n-3], fb[n-4]} == f);
        e.lerr = (n < 64) || (n > 1518);
        e.cerr = 1'b0;
        e.len  = n;
        expq.push_back(e);
    endtask

    task automatic send_partial(input int nwords);
        int due;
        drive(8'h01, SFD_WORD, due);
        for (int i = 0; i < nwords; i++) drive(8'h00, {$urandom, $urandom}, due);
    endtask

    task automatic compare_loop();
        exp_t e;
        bit   good;
        forever begin
            @(negedge clk);
            if (rst) begin
                mgood = 0;
                mbad  = 0;
                chk("rst_frame_done", frame_done, 0);
                chk("rst_good_cnt", good_cnt, 0);
                chk("rst_bad_cnt", bad_cnt, 0);
            end else begin
                if (frame_done) begin
                    checks++;
                    if (expq.size() == 0 || expq[0].due != cyc) begin
                        errors++;
                        $display("FAIL unexpected_done: frame_done got 1, required 0 (cycle %0d)", cyc);
                    end else begin
                        e = expq.pop_front();
                        good = e.ok && !e.lerr && !e.cerr;
                        chk("fcs_ok", fcs_ok, e.ok && !e.cerr);
                        chk("ctrl_err", ctrl_err, e.cerr);
                        chk("frame_good", frame_good, good);
                        if (!e.cerr) begin
                            chk("len_err", len_err, e.lerr);
                            chk("frame_len", frame_len, 64'(e.len));
                        end
                        if (good) mgood++; else mbad++;
                    end
                end else if (expq.size() != 0 && expq[0].due <= cyc) begin
                    e = expq.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_done: frame_done got 0, required 1 (cycle %0d)", cyc);
                    if (e.ok && !e.lerr && !e.cerr) mgood++; else mbad++;
                end
                chk("good_cnt", good_cnt, 64'(mgood));
                chk("bad_cnt", bad_cnt, 64'(mbad));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        int         due;
        exp_t       e;

        rst = 1'b1;
        xgmii_ctrl = 8'hFF;
        xgmii_data = IDLE_WORD;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_frame_done", frame_done, 0);
        chk("reset_fcs_ok", fcs_ok, 0);
        chk("reset_flags", {len_err, ctrl_err, frame_good}, 0);
        chk("reset_frame_len", frame_len, 0);
        chk("reset_counts", {good_cnt, bad_cnt}, 0);

        for (int i = 0; i < 9; i++) q.push_back(8'(8'h31 + i));
        chk("model_crc_pin", crc_bytes(q, 9), 32'hCBF43926);

        fork
            compare_loop();
        join_none

        // 64-byte good frame, /T/ in lane 0
        make_frame(64, 1'b0);
        send_frame(1'b0);
        idle(2);
        chk("pin_len64", frame_len, 64);
        chk("pin_fcs64", {fcs_ok, frame_good}, 2'b11);
        chk("pin_good_cnt1", good_cnt, 1);

        // /T/ in every lane
        for (int n = 64; n <= 71; n++) begin
            make_frame(n, 1'b0);
            send_frame(1'b0);
            idle(1);
        end

        // corrupted FCS
        make_frame(64, 1'b1);
        send_frame(1'b0);
        idle(2);
        chk("pin_badfcs", {fcs_ok, frame_good}, 2'b00);
        chk("pin_bad_cnt1", bad_cnt, 1);
        chk("pin_good_cnt9", good_cnt, 9);

        // length limits
        make_frame(60, 1'b0);
        send_frame(1'b0);
        idle(1);
        make_frame(1522, 1'b0);
        send_frame(1'b0);
        idle(2);
        chk("pin_len1522", {fcs_ok, len_err, frame_len}, {2'b11, 16'd1522});

        // /E/ in lane 4 mid-frame
        send_partial(3);
        drive(8'h10, {24'h123456, 8'hFE, 32'h89ABCDEF}, due);
        e = '{due: due, ok: 1'b0, lerr: 1'b0, cerr: 1'b1, len: -1};
        expq.push_back(e);
        idle(2);
        chk("pin_err_e", {ctrl_err, fcs_ok}, 2'b10);

        // new /S/ inside a frame, then the new frame is good
        send_partial(3);
        make_frame(66, 1'b0);
        send_frame(1'b1);
        idle(2);

        // reset mid-frame discards it
        send_partial(4);
        @(posedge clk);
        #1;
        rst = 1'b1;
        xgmii_ctrl = 8'hFF;
        xgmii_data = IDLE_WORD;
        repeat (2) @(posedge clk);
        #1;
        chk("pin_midrst_counts", {good_cnt, bad_cnt}, 0);
        rst = 1'b0;
        idle(1);

        // back-to-back frames without an idle word
        make_frame(65, 1'b0);
        send_frame(1'b0);
        make_frame(70, 1'b0);
        send_frame(1'b0);
        idle(2);
        chk("pin_b2b_good_cnt", good_cnt, 2);

        idle(4);
        chk("pending_completions", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
